kb_scr_cpu_port: RTL and testbench

CPU-side register port for the keyboard and screen devices. It decodes four byte-wide memory-mapped registers (KB CSR, KB DR, SCR CSR, SCR DR) and maintains the CSR status bits. It accepts bytes from the keyboard side, hands bytes to the screen side with a valid/ack handshake, and raises per-device interrupt requests. It sits between the CPU data bus and the keyboard/screen device drivers.

---
 rtl/kb_scr_cpu_port.sv | 185 ++++++++++++++++++
 tb/tb_kb_scr_cpu_port.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kb_scr_cpu_port.sv
// kb_scr_cpu_port: CPU-side register window for the keyboard and screen devices.
// Four byte registers at BASE..BASE+3 (KB CSR, KB DR, SCR CSR, SCR DR).
// CSR layout: bit4 ena, bit3 of, bit2 dba, bit1 io (read-only), bit0 ie.
module kb_scr_cpu_port #(
  parameter int                 ADDR_W = 16,
  parameter logic [ADDR_W-1:0]  BASE   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_hit,
  input  logic [7:0]        kb_byte,
  input  logic              kb_valid,
  output logic [7:0]        scr_byte,
  output logic              scr_valid,
  input  logic              scr_ack,
  output logic              kb_irq,
  output logic              scr_irq
);

  localparam logic [1:0] SEL_KB_CSR  = 2'd0;
  localparam logic [1:0] SEL_KB_DR   = 2'd1;
  localparam logic [1:0] SEL_SCR_CSR = 2'd2;
  localparam logic [1:0] SEL_SCR_DR  = 2'd3;

  // Keyboard register state
  logic       kb_ena_q, kb_ena_d;
  logic       kb_ie_q, kb_ie_d;
  logic       kb_of_q, kb_of_d;
  logic       kb_dba_q, kb_dba_d;
  logic [7:0] kb_dr_q, kb_dr_d;

  // Screen register state; dba=1 means the transmit buffer is empty
  logic       scr_ena_q, scr_ena_d;
  logic       scr_ie_q, scr_ie_d;
  logic       scr_of_q, scr_of_d;
  logic       scr_dba_q, scr_dba_d;
  logic [7:0] scr_dr_q, scr_dr_d;
  logic [7:0] scr_byte_q, scr_byte_d;
  logic       scr_valid_q, scr_valid_d;

  // Registered CPU response and interrupt lines
  logic [7:0] rdata_q, rdata_d;
  logic       hit_q, hit_d;
  logic       kb_irq_q, kb_irq_d;
  logic       scr_irq_q, scr_irq_d;

  // Address decode: the offset form keeps the window correct even if BASE+3 wraps
  logic [ADDR_W-1:0] offset;
  logic              in_range;
  logic [1:0]        reg_sel;
  logic              wr_en;
  logic              rd_en;
  logic              kb_dr_read;
  logic              scr_dr_write;
  logic              scr_ack_eff;
  logic              scr_dba_eff;
  logic [7:0]        kb_csr;
  logic [7:0]        scr_csr;

  assign offset       = cpu_addr - BASE;
  assign in_range     = (offset[ADDR_W-1:2] == '0);
  assign reg_sel      = offset[1:0];
  assign wr_en        = cpu_wr & in_range;
  assign rd_en        = cpu_rd & ~cpu_wr & in_range;
  assign kb_dr_read   = rd_en && (reg_sel == SEL_KB_DR);
  assign scr_dr_write = wr_en && (reg_sel == SEL_SCR_DR);
  assign scr_ack_eff  = scr_ack & scr_valid_q;
  assign scr_dba_eff  = scr_dba_q | scr_ack_eff;
  assign kb_csr       = {3'b000, kb_ena_q, kb_of_q, kb_dba_q, 1'b0, kb_ie_q};
  assign scr_csr      = {3'b000, scr_ena_q, scr_of_q, scr_dba_q, 1'b1, scr_ie_q};

  // Next-state logic for the register file, device handshakes and interrupts
  always_comb begin
    kb_ena_d    = kb_ena_q;
    kb_ie_d     = kb_ie_q;
    kb_of_d     = kb_of_q;
    kb_dba_d    = kb_dba_q;
    kb_dr_d     = kb_dr_q;
    scr_ena_d   = scr_ena_q;
    scr_ie_d    = scr_ie_q;
    scr_of_d    = scr_of_q;
    scr_dba_d   = scr_dba_eff;
    scr_dr_d    = scr_dr_q;
    scr_byte_d  = scr_byte_q;
    scr_valid_d = scr_valid_q & ~scr_ack_eff;
    rdata_d     = 8'h00;
    hit_d       = (cpu_rd | cpu_wr) & in_range;

    if (rd_en) begin
      case (reg_sel)
        SEL_KB_CSR:  rdata_d = kb_csr;
        SEL_KB_DR:   rdata_d = kb_dr_q;
        SEL_SCR_CSR: rdata_d = scr_csr;
        default:     rdata_d = scr_dr_q;
      endcase
    end

    if (wr_en && (reg_sel == SEL_KB_CSR)) begin
      kb_ena_d = cpu_wdata[4];
      kb_ie_d  = cpu_wdata[0];
      if (!cpu_wdata[3]) kb_of_d = 1'b0;
    end

    if (wr_en && (reg_sel == SEL_SCR_CSR)) begin
      scr_ena_d = cpu_wdata[4];
      scr_ie_d  = cpu_wdata[0];
      if (!cpu_wdata[3]) scr_of_d = 1'b0;
    end

    // A read of KB DR in the same cycle as a new byte is not an overrun
    if (kb_dr_read) kb_dba_d = 1'b0;
    if (kb_valid && kb_ena_q) begin
      kb_dr_d = kb_byte;
      if (kb_dba_q && !kb_dr_read) kb_of_d = 1'b1;
      kb_dba_d = 1'b1;
    end

    // An ack in the same cycle frees the buffer before the write is judged
    if (scr_dr_write && scr_ena_q) begin
      if (scr_dba_eff) begin
        scr_dr_d    = cpu_wdata;
        scr_byte_d  = cpu_wdata;
        scr_dba_d   = 1'b0;
        scr_valid_d = 1'b1;
      end else begin
        scr_of_d = 1'b1;
      end
    end

    kb_irq_d  = kb_ie_q & kb_ena_q & kb_dba_q;
    scr_irq_d = scr_ie_q & scr_ena_q & scr_dba_q;
  end

  // State registers with synchronous reset to the documented power-on values
  always_ff @(posedge clk) begin
    if (rst) begin
      kb_ena_q    <= 1'b0;
      kb_ie_q     <= 1'b0;
      kb_of_q     <= 1'b0;
      kb_dba_q    <= 1'b0;
      kb_dr_q     <= 8'h00;
      scr_ena_q   <= 1'b0;
      scr_ie_q    <= 1'b0;
      scr_of_q    <= 1'b0;
      scr_dba_q   <= 1'b1;
      scr_dr_q    <= 8'h00;
      scr_byte_q  <= 8'h00;
      scr_valid_q <= 1'b0;
      rdata_q     <= 8'h00;
      hit_q       <= 1'b0;
      kb_irq_q    <= 1'b0;
      scr_irq_q   <= 1'b0;
    end else begin
      kb_ena_q    <= kb_ena_d;
      kb_ie_q     <= kb_ie_d;
      kb_of_q     <= kb_of_d;
      kb_dba_q    <= kb_dba_d;
      kb_dr_q     <= kb_dr_d;
      scr_ena_q   <= scr_ena_d;
      scr_ie_q    <= scr_ie_d;
      scr_of_q    <= scr_of_d;
      scr_dba_q   <= scr_dba_d;
      scr_dr_q    <= scr_dr_d;
      scr_byte_q  <= scr_byte_d;
      scr_valid_q <= scr_valid_d;
      rdata_q     <= rdata_d;
      hit_q       <= hit_d;
      kb_irq_q    <= kb_irq_d;
      scr_irq_q   <= scr_irq_d;
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_hit   = hit_q;
  assign scr_byte  = scr_byte_q;
  assign scr_valid = scr_valid_q;
  assign kb_irq    = kb_irq_q;
  assign scr_irq   = scr_irq_q;

endmodule

// File: tb/tb_kb_scr_cpu_port.sv
// tb_kb_scr_cpu_port: directed bench for the keyboard/screen CPU register port.
// CPU accesses push their expected response into a queue; a monitor on the
// falling edge pops and compares whenever an access result is due.
module tb_kb_scr_cpu_port;

  localparam logic [15:0] BASE = 16'h0000;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_hit;
  logic [7:0]  kb_byte;
  logic        kb_valid;
  logic [7:0]  scr_byte;
  logic        scr_valid;
  logic        scr_ack;
  logic        kb_irq;
  logic        scr_irq;

  typedef struct {
    string      name;
    logic       hit;
    logic [7:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  logic acc_seen = 1'b0;

  kb_scr_cpu_port #(.ADDR_W(16), .BASE(BASE)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
    .kb_byte(kb_byte), .kb_valid(kb_valid),
    .scr_byte(scr_byte), .scr_valid(scr_valid), .scr_ack(scr_ack),
    .kb_irq(kb_irq), .scr_irq(scr_irq)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Remember whether a CPU access was sampled, so the monitor knows a response is due
  always @(posedge clk) acc_seen <= cpu_rd | cpu_wr;

  // Monitor: compare the registered CPU response against the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (acc_seen) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_response: hit=%0b rdata=%02h required no pending access", cpu_hit, cpu_rdata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (cpu_hit !== e.hit || cpu_rdata !== e.rdata) begin
            errors++;
            $display("[TB] FAIL %s: hit=%0b rdata=%02h required hit=%0b rdata=%02h",
                     e.name, cpu_hit, cpu_rdata, e.hit, e.rdata);
          end
        end
      end else begin
        checks++;
        if (cpu_hit !== 1'b0 || cpu_rdata !== 8'h00) begin
          errors++;
          $display("[TB] FAIL idle_response: hit=%0b rdata=%02h required hit=0 rdata=00", cpu_hit, cpu_rdata);
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exhausted");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic addrHit(input logic [15:0] a);
    logic [15:0] off;
    off = a - BASE;
    return off < 16'd4;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %02h required %02h", name, actual, expected);
    end
  endtask

  // One clock of stimulus: drive at the falling edge, release just after the rising edge
  task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                               input logic [7:0] wdata, input logic kbv, input logic [7:0] kbb,
                               input logic ack, input logic [7:0] exp_rdata, input string name);
    exp_t e;
    @(negedge clk);
    cpu_rd    = rd;
    cpu_wr    = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    kb_valid  = kbv;
    kb_byte   = kbb;
    scr_ack   = ack;
    if (rd || wr) begin
      e.name  = name;
      e.hit   = addrHit(addr);
      e.rdata = (rd && !wr && addrHit(addr)) ? exp_rdata : 8'h00;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cpu_rd   = 1'b0;
    cpu_wr   = 1'b0;
    kb_valid = 1'b0;
    scr_ack  = 1'b0;
  endtask

  task automatic cpuRead(input logic [15:0] addr, input logic [7:0] exp_rdata, input string name);
    applyStimulus(1'b1, 1'b0, addr, 8'h00, 1'b0, 8'h00, 1'b0, exp_rdata, name);
  endtask

  task automatic cpuWrite(input logic [15:0] addr, input logic [7:0] data, input string name);
    applyStimulus(1'b0, 1'b1, addr, data, 1'b0, 8'h00, 1'b0, 8'h00, name);
  endtask

  task automatic kbPulse(input logic [7:0] b);
    applyStimulus(1'b0, 1'b0, BASE, 8'h00, 1'b1, b, 1'b0, 8'h00, "kb_pulse");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cpu_addr = '0; cpu_rd = 0; cpu_wr = 0; cpu_wdata = 0;
    kb_byte = 0; kb_valid = 0; scr_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset state
    checkOutput("reset_scr_valid", {7'b0, scr_valid}, 8'h00);
    checkOutput("reset_scr_byte", scr_byte, 8'h00);
    checkOutput("reset_kb_irq", {7'b0, kb_irq}, 8'h00);
    checkOutput("reset_scr_irq", {7'b0, scr_irq}, 8'h00);
    cpuRead(BASE + 16'd0, 8'h00, "reset_kb_csr");
    cpuRead(BASE + 16'd1, 8'h00, "reset_kb_dr");
    cpuRead(BASE + 16'd2, 8'h06, "reset_scr_csr");
    cpuRead(BASE + 16'd3, 8'h00, "reset_scr_dr");

    // Keyboard receive, interrupt lag and overrun
    cpuWrite(BASE + 16'd0, 8'h11, "kb_csr_enable");
    kbPulse(8'h41);
    checkOutput("kb_irq_lag", {7'b0, kb_irq}, 8'h00);
    idle(1);
    checkOutput("kb_irq_set", {7'b0, kb_irq}, 8'h01);
    cpuRead(BASE + 16'd0, 8'h15, "kb_csr_after_rx");
    kbPulse(8'h42);
    cpuRead(BASE + 16'd0, 8'h1D, "kb_csr_overrun");
    cpuRead(BASE + 16'd1, 8'h42, "kb_dr_second_byte");
    cpuRead(BASE + 16'd0, 8'h19, "kb_csr_after_dr_read");
    cpuWrite(BASE + 16'd0, 8'h11, "kb_csr_clear_of");
    cpuRead(BASE + 16'd0, 8'h11, "kb_csr_of_cleared");

    // Screen send, drop on busy, acknowledge
    cpuWrite(BASE + 16'd2, 8'h10, "scr_csr_enable");
    cpuWrite(BASE + 16'd3, 8'h55, "scr_dr_write_55");
    checkOutput("scr_valid_rise", {7'b0, scr_valid}, 8'h01);
    checkOutput("scr_byte_55", scr_byte, 8'h55);
    cpuRead(BASE + 16'd2, 8'h12, "scr_csr_busy");
    cpuWrite(BASE + 16'd3, 8'h66, "scr_dr_write_dropped");
    cpuRead(BASE + 16'd2, 8'h1A, "scr_csr_overrun");
    checkOutput("scr_byte_held", scr_byte, 8'h55);
    cpuRead(BASE + 16'd3, 8'h55, "scr_dr_last_accepted");
    applyStimulus(1'b0, 1'b0, BASE, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, "scr_ack");
    checkOutput("scr_valid_fall", {7'b0, scr_valid}, 8'h00);
    cpuRead(BASE + 16'd2, 8'h1E, "scr_csr_after_ack");
    checkOutput("scr_irq_ie_off", {7'b0, scr_irq}, 8'h00);

    // Write and ack in the same cycle
    cpuWrite(BASE + 16'd3, 8'h60, "scr_dr_write_60");
    checkOutput("scr_byte_60", scr_byte, 8'h60);
    applyStimulus(1'b0, 1'b1, BASE + 16'd3, 8'h77, 1'b0, 8'h00, 1'b1, 8'h00, "scr_dr_write_with_ack");
    checkOutput("scr_valid_kept", {7'b0, scr_valid}, 8'h01);
    checkOutput("scr_byte_77", scr_byte, 8'h77);
    cpuRead(BASE + 16'd2, 8'h1A, "scr_csr_ack_write");
    cpuRead(BASE + 16'd3, 8'h77, "scr_dr_77");

    // Keyboard byte arriving during a KB DR read
    kbPulse(8'h43);
    applyStimulus(1'b1, 1'b0, BASE + 16'd1, 8'h00, 1'b1, 8'h44, 1'b0, 8'h43, "kb_dr_read_with_rx");
    cpuRead(BASE + 16'd0, 8'h15, "kb_csr_read_with_rx");
    cpuRead(BASE + 16'd1, 8'h44, "kb_dr_new_byte");

    // Disabled keyboard and address decode
    cpuWrite(BASE + 16'd0, 8'h00, "kb_csr_disable");
    kbPulse(8'h99);
    cpuRead(BASE + 16'd1, 8'h44, "kb_dr_disabled");
    cpuRead(BASE + 16'd0, 8'h00, "kb_csr_disabled");
    cpuWrite(BASE + 16'd4, 8'hFF, "write_out_of_range");
    cpuRead(BASE + 16'd0, 8'h00, "kb_csr_no_alias");
    cpuRead(BASE + 16'd5, 8'h00, "read_out_of_range");
    applyStimulus(1'b1, 1'b1, BASE + 16'd0, 8'h11, 1'b0, 8'h00, 1'b0, 8'h00, "rd_wr_together");
    cpuRead(BASE + 16'd0, 8'h11, "kb_csr_after_rd_wr");

    // Reset with a screen byte pending and a keyboard byte waiting
    kbPulse(8'h55);
    idle(1);
    checkOutput("pre_reset_kb_irq", {7'b0, kb_irq}, 8'h01);
    checkOutput("pre_reset_scr_valid", {7'b0, scr_valid}, 8'h01);
    pulseReset();
    checkOutput("post_reset_scr_valid", {7'b0, scr_valid}, 8'h00);
    checkOutput("post_reset_scr_byte", scr_byte, 8'h00);
    checkOutput("post_reset_kb_irq", {7'b0, kb_irq}, 8'h00);
    cpuRead(BASE + 16'd0, 8'h00, "post_reset_kb_csr");
    cpuRead(BASE + 16'd1, 8'h00, "post_reset_kb_dr");
    cpuRead(BASE + 16'd2, 8'h06, "post_reset_scr_csr");
    cpuRead(BASE + 16'd3, 8'h00, "post_reset_scr_dr");

    // Screen interrupt follows dba with one cycle of lag
    cpuWrite(BASE + 16'd2, 8'h11, "scr_csr_ie");
    checkOutput("scr_irq_lag", {7'b0, scr_irq}, 8'h00);
    idle(1);
    checkOutput("scr_irq_set", {7'b0, scr_irq}, 8'h01);
    cpuWrite(BASE + 16'd3, 8'hA5, "scr_dr_write_a5");
    checkOutput("scr_irq_still_set", {7'b0, scr_irq}, 8'h01);
    idle(1);
    checkOutput("scr_irq_clear", {7'b0, scr_irq}, 8'h00);
    checkOutput("scr_byte_a5", scr_byte, 8'hA5);

    idle(3);
    checkOutput("scoreboard_drained", 8'(exp_q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
